// File: rtl/mux_pkg.sv
// Shared constants for the N:1 scanning channel multiplexer.
// Holds the mode encoding and the EMPTY/FULL state encoding.
package mux_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

endpackage

// File: rtl/mux_scan_ptr.sv
// Modulo-N_CH scan pointer with a last-channel flag.
// Advances only on i_adv and wraps from N_CH-1 back to 0.
module mux_scan_ptr #(
    parameter int N_CH  = 8,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_adv,
    output logic [SEL_W-1:0] o_ptr,
    output logic             o_last
);

    logic [SEL_W-1:0] ptr_q;

    assign o_ptr  = ptr_q;
    assign o_last = (ptr_q == SEL_W'(N_CH - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_q <= '0;
        end else if (i_adv) begin
            ptr_q <= o_last ? '0 : ptr_q + 1'b1;
        end
    end

endmodule

// File: rtl/mux_n_1_scan.sv
// Registered N:1 channel mux with valid/ready output and auto-scan.
// Define MUX_N_1_SCAN_TRISTATE_EN to float o_f whenever o_valid is low.
module mux_n_1_scan
    import mux_pkg::*;
#(
    parameter  int N_CH  = 8,
    parameter  int W     = 1,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_mode,
    input  logic [N_CH*W-1:0] i_code,
    input  logic [SEL_W-1:0]  i_sel_code,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [W-1:0]      o_f,
    output logic [SEL_W-1:0]  o_ch,
    output logic              o_wrap
);

    logic [0:0]       st_q;
    logic [W-1:0]     f_q;
    logic [SEL_W-1:0] ch_q;
    logic             wrap_q;

    logic             scan;
    logic             load;
    logic [SEL_W-1:0] ptr;
    logic             ptr_last;
    logic [SEL_W-1:0] idx;
    logic [W-1:0]     sel_data;

    assign scan = (i_mode == MODE_SCAN);
    // i_ready reaches load combinationally so a full register can refill
    assign load = i_en & ((st_q == ST_EMPTY) | i_ready);
    assign idx  = scan ? ptr : i_sel_code;

    mux_scan_ptr #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_ptr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_adv   (load & scan),
        .o_ptr   (ptr),
        .o_last  (ptr_last)
    );

    // Out-of-range indices fall through to the all-zero default
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (idx == SEL_W'(k)) begin
                sel_data = i_code[k*W +: W];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            st_q   <= ST_EMPTY;
            f_q    <= '0;
            ch_q   <= '0;
            wrap_q <= 1'b0;
        end else if (load) begin
            st_q   <= ST_FULL;
            f_q    <= sel_data;
            ch_q   <= idx;
            wrap_q <= scan & ptr_last;
        end else if ((st_q == ST_FULL) && i_ready) begin
            st_q   <= ST_EMPTY;
        end
    end

    assign o_valid = (st_q == ST_FULL);
    assign o_ch    = ch_q;
    assign o_wrap  = wrap_q;

`ifdef MUX_N_1_SCAN_TRISTATE_EN
    assign o_f = o_valid ? f_q : {W{1'bz}};
`else
    assign o_f = o_valid ? f_q : '0;
`endif

endmodule

// File: tb/tb_mux_n_1_scan.sv
// Self-checking bench: an 8-channel and a 5-channel instance side by side.
// Expected outputs come from a per-instance model of the handshake rules.
module tb_mux_n_1_scan;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        mode;
    logic [2:0]  sel;
    logic        rdy;
    logic [31:0] code8;
    logic [19:0] code5;

    logic        v8, w8, v5, w5;
    logic [3:0]  f8, f5;
    logic [2:0]  ch8, ch5;

`ifdef MUX_N_1_SCAN_TRISTATE_EN
    localparam logic [3:0] F_IDLE = 4'bzzzz;
`else
    localparam logic [3:0] F_IDLE = 4'h0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic       m_v [2];
    logic       m_w [2];
    logic [3:0] m_f [2];
    logic [2:0] m_ch[2];
    int         m_p [2];
    int         nch [2] = '{8, 5};

    mux_n_1_scan #(.N_CH(8), .W(4)) dut8 (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_en       (en),
        .i_mode     (mode),
        .i_code     (code8),
        .i_sel_code (sel),
        .i_ready    (rdy),
        .o_valid    (v8),
        .o_f        (f8),
        .o_ch       (ch8),
        .o_wrap     (w8)
    );

    mux_n_1_scan #(.N_CH(5), .W(4)) dut5 (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_en       (en),
        .i_mode     (mode),
        .i_code     (code5),
        .i_sel_code (sel),
        .i_ready    (rdy),
        .o_valid    (v5),
        .o_f        (f5),
        .o_ch       (ch5),
        .o_wrap     (w5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] chan(int d, int k);
        if (d == 0) return code8[k*4 +: 4];
        return code5[k*4 +: 4];
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_v[d] = 1'b0; m_w[d] = 1'b0;
            m_f[d] = 4'h0; m_ch[d] = 3'd0;
            m_p[d] = 0;
        end
    endtask

    // Apply one clock edge of the handshake rules to both models
    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            if (en && (!m_v[d] || rdy)) begin
                m_v[d] = 1'b1;
                if (mode) begin
                    m_ch[d] = 3'(m_p[d]);
                    m_f[d]  = chan(d, m_p[d]);
                    m_w[d]  = (m_p[d] == nch[d] - 1);
                    m_p[d]  = (m_p[d] + 1) % nch[d];
                end else begin
                    m_ch[d] = sel;
                    m_f[d]  = (int'(sel) < nch[d]) ? chan(d, int'(sel)) : 4'h0;
                    m_w[d]  = 1'b0;
                end
            end else if (m_v[d] && rdy) begin
                m_v[d] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #3;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        en = 0; mode = 0; sel = 0; rdy = 0; code8 = 0; code5 = 0;
        rst_n = 1'b0;
        model_reset();
        #12;
        n_cmp++;
        if (v8 !== 1'b0 || ch8 !== 3'd0 || w8 !== 1'b0 || f8 !== F_IDLE) begin
            n_err++;
            $display("FAIL reset_init: v=%b f=%h ch=%0d w=%b want v=0 f=%h ch=0 w=0",
                     v8, f8, ch8, w8, F_IDLE);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        en = 1; mode = 1; rdy = 0;
        code8 = $urandom; code5 = 20'($urandom);
        tick();
        tick();
        n_cmp++;
        if (v8 !== 1'b1) begin
            n_err++;
            $display("FAIL reset_prefill: v=%b want 1", v8);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (v8 !== 1'b0 || ch8 !== 3'd0 || w8 !== 1'b0 || f8 !== F_IDLE) begin
            n_err++;
            $display("FAIL reset_async8: v=%b f=%h ch=%0d w=%b want v=0 f=%h ch=0 w=0",
                     v8, f8, ch8, w8, F_IDLE);
        end
        n_cmp++;
        if (v5 !== 1'b0 || ch5 !== 3'd0 || w5 !== 1'b0 || f5 !== F_IDLE) begin
            n_err++;
            $display("FAIL reset_async5: v=%b f=%h ch=%0d w=%b want v=0 f=%h ch=0 w=0",
                     v5, f5, ch5, w5, F_IDLE);
        end
        rst_n = 1'b1;
        en = 0;
    endtask

    task automatic test_direct();
        code8 = $urandom;
        code8[23:20] = 4'hA;
        code5 = 20'($urandom);
        mode = 0; sel = 3'd5; en = 1; rdy = 1;
        tick();
        n_cmp++;
        if (v8 !== 1'b1 || f8 !== 4'hA || ch8 !== 3'd5) begin
            n_err++;
            $display("FAIL direct: v=%b f=%h ch=%0d want v=1 f=a ch=5", v8, f8, ch8);
        end
    endtask

    task automatic test_backpressure();
        rdy = 0;
        for (int i = 0; i < 3; i++) begin
            sel = 3'($urandom_range(0, 7));
            mode = 1'($urandom);
            code8 = $urandom; code5 = 20'($urandom);
            tick();
            n_cmp++;
            if (v8 !== 1'b1 || f8 !== 4'hA || ch8 !== 3'd5) begin
                n_err++;
                $display("FAIL backpressure_hold%0d: v=%b f=%h ch=%0d want v=1 f=a ch=5",
                         i, v8, f8, ch8);
            end
        end
        mode = 0; sel = 3'd2; rdy = 1;
        code8 = $urandom;
        code8[11:8] = 4'h3;
        tick();
        n_cmp++;
        if (v8 !== 1'b1 || f8 !== 4'h3 || ch8 !== 3'd2) begin
            n_err++;
            $display("FAIL backpressure_release: v=%b f=%h ch=%0d want v=1 f=3 ch=2",
                     v8, f8, ch8);
        end
    endtask

    task automatic test_scan_wrap();
        int exp_ch[7] = '{0, 1, 2, 3, 4, 0, 1};
        en = 0;
        @(posedge clk); #1;
        do_reset();
        en = 1; mode = 1; rdy = 1;
        for (int i = 0; i < 7; i++) begin
            code8 = $urandom; code5 = 20'($urandom);
            tick();
            n_cmp++;
            if (v5 !== 1'b1 || ch5 !== 3'(exp_ch[i]) || w5 !== (exp_ch[i] == 4)
                || f5 !== m_f[1]) begin
                n_err++;
                $display("FAIL scan_wrap%0d: v=%b ch=%0d w=%b f=%h want v=1 ch=%0d w=%b f=%h",
                         i, v5, ch5, w5, f5, exp_ch[i], exp_ch[i] == 4, m_f[1]);
            end
        end
    endtask

    task automatic test_out_of_range();
        mode = 0; sel = 3'd6; en = 1; rdy = 1;
        code5 = 20'hFFFFF;
        tick();
        n_cmp++;
        if (v5 !== 1'b1 || f5 !== 4'h0 || ch5 !== 3'd6 || w5 !== 1'b0) begin
            n_err++;
            $display("FAIL out_of_range: v=%b f=%h ch=%0d w=%b want v=1 f=0 ch=6 w=0",
                     v5, f5, ch5, w5);
        end
    endtask

    task automatic test_drain();
        int held;
        mode = 1; en = 1; rdy = 1;
        tick();
        tick();
        held = m_p[1];
        en = 0; rdy = 1;
        tick();
        n_cmp++;
        if (v5 !== 1'b0 || v8 !== 1'b0 || f5 !== F_IDLE) begin
            n_err++;
            $display("FAIL drain: v5=%b v8=%b f5=%h want v5=0 v8=0 f5=%h",
                     v5, v8, f5, F_IDLE);
        end
        mode = 0;
        tick();
        mode = 1; en = 1;
        code5 = 20'($urandom);
        tick();
        n_cmp++;
        if (v5 !== 1'b1 || ch5 !== 3'(held) || f5 !== chan(1, held)) begin
            n_err++;
            $display("FAIL drain_resume: v=%b ch=%0d f=%h want v=1 ch=%0d f=%h",
                     v5, ch5, f5, held, chan(1, held));
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            en    = ($urandom_range(0, 3) != 0);
            mode  = 1'($urandom);
            sel   = 3'($urandom_range(0, 7));
            rdy   = ($urandom_range(0, 2) != 0);
            code8 = $urandom;
            code5 = 20'($urandom);
            tick();
            n_cmp++;
            if (v8 !== m_v[0] || (m_v[0] && (f8 !== m_f[0] || ch8 !== m_ch[0]
                || w8 !== m_w[0])) || (!m_v[0] && f8 !== F_IDLE)) begin
                n_err++;
                $display("FAIL random8 %0d: v=%b f=%h ch=%0d w=%b want v=%b f=%h ch=%0d w=%b",
                         i, v8, f8, ch8, w8, m_v[0], m_f[0], m_ch[0], m_w[0]);
            end
            n_cmp++;
            if (v5 !== m_v[1] || (m_v[1] && (f5 !== m_f[1] || ch5 !== m_ch[1]
                || w5 !== m_w[1])) || (!m_v[1] && f5 !== F_IDLE)) begin
                n_err++;
                $display("FAIL random5 %0d: v=%b f=%h ch=%0d w=%b want v=%b f=%h ch=%0d w=%b",
                         i, v5, f5, ch5, w5, m_v[1], m_f[1], m_ch[1], m_w[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_backpressure();
        test_scan_wrap();
        test_out_of_range();
        test_drain();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
